karatsuba_issue_seq: RTL

Operand-issue sequencer that sits directly upstream of the 32x32 iterative Karatsuba multiplier core. It buffers incoming operand pairs in a small FIFO, restarts and steps the core once per pair, captures the 64-bit product when the core raises `done`, and presents it on a valid/ready result port. This turns the core's restart-and-run protocol into a streaming interface.

---
 rtl/karatsuba_issue_seq.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/karatsuba_issue_seq.sv
// Streaming front end for the restart-and-run 32x32 Karatsuba core: buffers operand
// pairs, sequences the core per pair and holds each product on a valid/ready port.
// Optional RUN watchdog: define KARATSUBA_SEQ_TIMEOUT_EN to force a capture after TIMEOUT cycles.
module karatsuba_issue_seq #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        mul_rst,
  output logic        mul_en,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_c,
  input  logic        mul_done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("karatsuba_issue_seq: DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT < 5 || TIMEOUT > 255) begin : g_bad_timeout
    $error("karatsuba_issue_seq: TIMEOUT must be in 5..255");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [31:0]   mem_a [DEPTH];
  logic [31:0]   mem_b [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          capture;
  logic          timeout_hit;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = ~full;
  assign push     = in_valid & ~full;
  assign capture  = (state == RUN) & (mul_done | timeout_hit);
  assign pop      = capture;
  // Head entry stays put from CLEAR until the capture pops it.
  assign mul_a    = mem_a[rd_ptr];
  assign mul_b    = mem_b[rd_ptr];

  always_comb begin
    count_next = count;
    if (push & ~pop) begin
      count_next = count + (AW+1)'(1);
    end else if (pop & ~push) begin
      count_next = count - (AW+1)'(1);
    end else begin
      count_next = count;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!empty) state_next = CLEAR; else state_next = IDLE;
      CLEAR:   state_next = RUN;
      RUN:     if (capture) state_next = OUT; else state_next = RUN;
      OUT: begin
        if (out_ready) state_next = (count_next != '0) ? CLEAR : IDLE;
        else           state_next = OUT;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mul_rst   = rst;
    mul_en    = 1'b0;
    out_valid = 1'b0;
    case (state)
      CLEAR:   mul_rst   = 1'b1;
      RUN:     mul_en    = 1'b1;
      OUT:     out_valid = 1'b1;
      default: mul_en    = 1'b0;
    endcase
    busy = (state != IDLE) | ~empty;
  end

  always_ff @(posedge clk) begin
    if (rst)          out_data <= '0;
    else if (capture) out_data <= mul_c;
  end

`ifdef KARATSUBA_SEQ_TIMEOUT_EN
  logic [7:0] run_cnt;

  // Counts cycles spent in RUN; restarts whenever the core is not running.
  always_ff @(posedge clk) begin
    if (rst || state != RUN) run_cnt <= 8'd0;
    else                     run_cnt <= run_cnt + 8'd1;
  end

  assign timeout_hit = (run_cnt == 8'(TIMEOUT - 1));

  // A genuine done on the deadline cycle still reports a clean result.
  always_ff @(posedge clk) begin
    if (rst)          out_err <= 1'b0;
    else if (capture) out_err <= ~mul_done;
  end
`else
  assign timeout_hit = 1'b0;
  assign out_err     = 1'b0;
`endif

endmodule
